param_pipelined_addsub: RTL and testbench
=========================================

Name: param_pipelined_addsub

Overview:
- N-bit adder/subtractor, pipelined into STAGES equal carry-chunks, with a registered carry passed between stages.
- Operands enter through a valid/ready handshake, and results leave through one. Bubbles collapse, and backpressure is honoured.
- Intended as the datapath-arithmetic building block for wide accumulators and ALUs, where a single-cycle ripple chain cannot meet timing.

Parameters:
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline stages. WIDTH % STAGES must be 0, otherwise elaboration fails. CW = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result, LSB chunk first in the pipeline, deskewed at output
- cout  output  1  carry out of the MSB (for sub=1: 1 means no borrow)
- overflow  output  1  signed two's-complement overflow of this beat

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits and data registers clear to 0.
  - out_valid=0, sum=0, cout=0, overflow=0.
  - in_ready=1 once the stage-0 register is empty, which it is after reset.
  - Asserting reset mid-operation discards every in-flight beat; nothing is emitted for those beats.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and of b' (b' = sub ? ~b : b), plus carry c[k].
  - c[0] = sub ? 1 : cin.
  - c[k+1] is the registered carry out of stage k.
  - Upper operand chunks travel with the beat through skew registers.
  - Computed lower result chunks travel with the beat through deskew registers.
  - The whole beat (operands, partial sum, carry, sub) moves as one unit.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles later, when there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
  - in_valid may not depend on in_ready.
  - Once out_valid=1, sum, cout and overflow hold stable until out_ready.
- Stall and bubble collapse:
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - Last stage: stage_ready = !out_valid || out_ready.
  - in_ready = stage_ready[0].
  - A stalled stage holds its data. Empty stages ahead of it keep filling, so the pipeline holds up to STAGES beats.
- Simultaneous output accept and input accept while full: both transfer in the same cycle, with no lost or duplicated beat.
- overflow = carry into MSB XOR carry out of MSB, evaluated in the final stage.
- Arithmetic is modulo 2^WIDTH; wrap-around is the default behaviour.
- STAGES=1: a single register stage with latency 1, and the same handshake.
- STAGES=WIDTH: 1-bit chunks; legal.

Optional Feature:
- Macro: ADDER_SATURATE_EN.
- Defined: when overflow=1 in the final stage, sum is replaced by a signed saturated value. Positive overflow (a[MSB]=0) gives 0111…1; negative overflow gives 1000…0. The overflow flag is still reported, and cout is unchanged.
- Not defined: sum is the raw wrapped result.
- Latency and handshake are identical in both builds.

Test Plan:
1. WIDTH=16, STAGES=4, out_ready=1, beats a=0x00FF, b=0x0001, cin=0, sub=0, then a=0xFFFF, b=0x0001:
   - First result 4 cycles after acceptance: sum=0x0100, cout=0, overflow=0.
   - Next cycle: sum=0x0000, cout=1, overflow=0. The carry propagates across all chunks.
2. sub=1, a=0x0005, b=0x0007: sum=0xFFFE, cout=0, overflow=0. Then a=0x8000, b=0x0001: sum=0x7FFF, cout=1, overflow=1.
3. Overflow 0x7FFF + 0x0001, sub=0:
   - Without the macro: sum=0x8000, overflow=1.
   - With ADDER_SATURATE_EN: sum=0x7FFF, overflow=1.
4. Backpressure:
   - Stream 10 beats (a=i, b=i) with out_ready=0. Exactly 4 are accepted, then in_ready=0, and sum holds 0x0000.
   - Raise out_ready: results 0,2,4,…,18 arrive in order, with none lost or duplicated.
   - Random in_valid/out_ready over 1000 beats matches the reference model.
5. Reset mid-flight: with 3 beats in the pipeline, pulse rst_n low for half a cycle, asynchronously to clk.
   - Outputs go immediately to out_valid=0, sum=0, overflow=0.
   - No stale beat appears afterwards. The next accepted beat emerges with latency 4.
6. Parameter sweep: (WIDTH, STAGES) = (8,1), (8,8), (32,4).
   - Exhaustive (8-bit) or random (32-bit) a/b/cin/sub against a behavioural model.
   - Latency equals STAGES in each case.
   - WIDTH=10, STAGES=4 fails elaboration.

Source files
------------

// File: rtl/param_pipelined_addsub.sv
// param_pipelined_addsub
// WIDTH-bit adder/subtractor split into STAGES carry chunks of CW = WIDTH/STAGES
// bits. Each stage adds one chunk and registers the carry for the next stage.
// Operands not yet consumed and result chunks already produced travel with the
// beat, so the sum leaves the last stage deskewed. Valid/ready on both sides,
// with per-stage ready so that bubbles collapse under backpressure.
// Optional build macro: ADDER_SATURATE_EN (signed saturation of sum on overflow).

module param_pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // The chunked datapath only works for equal-width chunks of a real word.
  generate
    if ((WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("param_pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
    end
  endgenerate

  // Saturation bound selected by the sign of the operands that overflowed.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    if (neg) begin
      return SAT_NEG;
    end else begin
      return SAT_POS;
    end
  endfunction

  // Stage registers: a full beat per stage (operands, partial sum, carry).
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic              r_ovf;

  // Per-stage inputs (what stage k sees) and next values (what it would load).
  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_v_src;
  logic [WIDTH-1:0]  w_a_src [STAGES];
  logic [WIDTH-1:0]  w_b_src [STAGES];
  logic [WIDTH-1:0]  w_s_src [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [WIDTH-1:0]  w_s_nx  [STAGES];
  logic [STAGES-1:0] w_c_nx;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_last_sum;

  // Ready chain: a stage can load if it, or any stage downstream, has a hole,
  // or the consumer takes the result; written without a self-referencing vector.
  always_comb begin
    logic v_acc;
    v_acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_acc    = v_acc | ~r_vld[k];
      w_rdy[k] = v_acc;
    end
  end

  // Stage sources: stage 0 takes the port operands (b inverted for subtract,
  // carry forced to 1), every later stage takes the previous stage register.
  always_comb begin
    w_v_src[0] = in_valid;
    w_a_src[0] = a;
    if (sub) begin
      w_b_src[0] = ~b;
      w_c_src[0] = 1'b1;
    end else begin
      w_b_src[0] = b;
      w_c_src[0] = cin;
    end
    w_s_src[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      w_v_src[k] = r_vld[k-1];
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_s_src[k] = r_s[k-1];
      w_c_src[k] = r_c[k-1];
    end
  end

  // Chunk adders: stage k fills result chunk k and produces the carry for k+1.
  always_comb begin
    logic [CW:0] v_res;
    v_res = {(CW+1){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      v_res = {1'b0, w_a_src[k][k*CW +: CW]}
            + {1'b0, w_b_src[k][k*CW +: CW]}
            + {{CW{1'b0}}, w_c_src[k]};
      w_s_nx[k]              = w_s_src[k];
      w_s_nx[k][k*CW +: CW]  = v_res[CW-1:0];
      w_c_nx[k]              = v_res[CW];
    end
  end

  // Final-stage overflow: the carry into the MSB is a^b'^s at that bit, so
  // carry-in XOR carry-out of the MSB reduces to a^b'^s^cout.
  always_comb begin
    w_ovf = w_a_src[STAGES-1][WIDTH-1] ^ w_b_src[STAGES-1][WIDTH-1]
          ^ w_s_nx[STAGES-1][WIDTH-1]  ^ w_c_nx[STAGES-1];
`ifdef ADDER_SATURATE_EN
    if (w_ovf) begin
      w_last_sum = sat_value(w_a_src[STAGES-1][WIDTH-1]);
    end else begin
      w_last_sum = w_s_nx[STAGES-1];
    end
`else
    w_last_sum = w_s_nx[STAGES-1];
`endif
  end

  // Pipeline registers: a ready stage takes its upstream beat (or a bubble);
  // a stalled stage holds everything, so the output stays stable until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= {STAGES{1'b0}};
      r_c   <= {STAGES{1'b0}};
      r_ovf <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= {WIDTH{1'b0}};
        r_b[k] <= {WIDTH{1'b0}};
        r_s[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_v_src[k];
          if (w_v_src[k]) begin
            r_a[k] <= w_a_src[k];
            r_b[k] <= w_b_src[k];
            r_c[k] <= w_c_nx[k];
            if (k == STAGES - 1) begin
              r_s[k] <= w_last_sum;
            end else begin
              r_s[k] <= w_s_nx[k];
            end
          end
        end
      end
      if (w_rdy[STAGES-1] && w_v_src[STAGES-1]) begin
        r_ovf <= w_ovf;
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_param_pipelined_addsub.sv
// Self-checking bench for param_pipelined_addsub: directed vector table,
// back-to-back carry, backpressure, mid-flight reset, random handshake
// against a plain-arithmetic model, and a parameter sweep on extra instances.

module tb_param_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

`ifdef ADDER_SATURATE_EN
  localparam logic [15:0] E_SUB_OVF = 16'h8000;
  localparam logic [15:0] E_ADD_OVF = 16'h7FFF;
  localparam logic [15:0] E_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] E_SUB_OVF = 16'h7FFF;
  localparam logic [15:0] E_ADD_OVF = 16'h8000;
  localparam logic [15:0] E_NEG_OVF = 16'h0000;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, sum;

  logic        sw_valid, sw_ready, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        rdy1, v1, c1, o1, rdy2, v2, c2, o2, rdy3, v3, c3, o3;
  logic [7:0]  s1, s2;
  logic [31:0] s3;

  int checks = 0;
  int errors = 0;
  exp_t swq [3][$];
  res_t mq [$];

  param_pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow));

  param_pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_8_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy1),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v1),
    .out_ready(sw_ready), .sum(s1), .cout(c1), .overflow(o1));

  param_pipelined_addsub #(.WIDTH(8), .STAGES(8)) dut_8_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy2),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v2),
    .out_ready(sw_ready), .sum(s2), .cout(c2), .overflow(o2));

  param_pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut_32_4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy3),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v3),
    .out_ready(sw_ready), .sum(s3), .cout(c3), .overflow(o3));

  // Reference: true unsigned and signed arithmetic on w-bit values.
  function automatic res_t ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                     input logic ci, input logic sb);
    longint full, ua, ub, tot, sa, sbv, sr, ciw;
    res_t r;
    full = 64'sd1 <<< w;
    ua   = longint'({32'd0, av}) & (full - 64'sd1);
    ub   = longint'({32'd0, bv}) & (full - 64'sd1);
    ciw  = ci ? 64'sd1 : 64'sd0;
    if (sb) tot = ua + (full - ub);
    else    tot = ua + ub + ciw;
    r.cout = (tot >= full);
    r.sum  = 32'(tot % full);
    sa  = (ua >= full / 2) ? ua - full : ua;
    sbv = (ub >= full / 2) ? ub - full : ub;
    sr  = sb ? (sa - sbv) : (sa + sbv + ciw);
    r.ovf = (sr > full / 2 - 64'sd1) || (sr < -(full / 2));
`ifdef ADDER_SATURATE_EN
    if (r.ovf) r.sum = (sr > 64'sd0) ? 32'(full / 2 - 64'sd1) : 32'(full / 2);
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sends one beat with out_ready=1 and measures edges until out_valid.
  task automatic send_one(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic sb, output int lat, output logic [15:0] rs,
                          output logic rc, output logic ro);
    int n;
    in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick(); #1; n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick(); lat++;
    end
    rs = sum; rc = cout; ro = overflow;
  endtask

  // Sweep monitor for one extra instance (accept -> push, output -> compare).
  task automatic sw_mon(input int idx, input int w, input int st, input logic rdy,
                        input logic vld, input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    if (sw_valid && rdy) swq[idx].push_back('{ref_model(w, sw_a, sw_b, sw_cin, sw_sub), cyc_cnt});
    if (vld) begin
      if (swq[idx].size() == 0) begin
        checks++; errors++;
        $display("FAIL sweep%0d_extra: got unexpected beat sum %0h expected none", idx, s);
      end else begin
        e = swq[idx].pop_front();
        chk($sformatf("sweep%0d_sum", idx), {32'd0, s}, {32'd0, e.r.sum});
        chk($sformatf("sweep%0d_cout", idx), {63'd0, c}, {63'd0, e.r.cout});
        chk($sformatf("sweep%0d_ovf", idx), {63'd0, o}, {63'd0, e.r.ovf});
        chk($sformatf("sweep%0d_latency", idx), 64'(cyc_cnt - e.cyc), 64'(st));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [10];
    int          lat, acc, got, n, beats;
    logic [15:0] rs, hs;
    logic        rc, ro, hc, ho, hold;
    res_t        e;

    vecs[0] = '{"add_00ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{"add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, E_SUB_OVF, 1'b1, 1'b1};
    vecs[4] = '{"add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, E_ADD_OVF, 1'b0, 1'b1};
    vecs[5] = '{"add_cin",      16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[6] = '{"sub_cin_ign",  16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"sub_0_0",      16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{"add_neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, E_NEG_OVF, 1'b1, 1'b1};
    vecs[9] = '{"add_m1_m1_c",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_a = 32'h0; sw_b = 32'h0; sw_cin = 1'b0; sw_sub = 1'b0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {48'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Directed vectors, one beat at a time.
    for (int i = 0; i < 10; i++) begin
      send_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, rs, rc, ro);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(S));
      chk({vecs[i].name, "_sum"}, {48'd0, rs}, {48'd0, vecs[i].esum});
      chk({vecs[i].name, "_cout"}, {63'd0, rc}, {63'd0, vecs[i].ecout});
      chk({vecs[i].name, "_ovf"}, {63'd0, ro}, {63'd0, vecs[i].eovf});
      tick();
    end

    // Back-to-back beats: results on consecutive cycles.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    tick();
    a = 16'hFFFF; b = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("b2b_first_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_first_sum", {48'd0, sum}, 64'h0100);
    tick();
    chk("b2b_second_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_second_sum", {48'd0, sum}, 64'h0000);
    chk("b2b_second_cout", {63'd0, cout}, 64'd1);
    tick();
    chk("b2b_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: pipeline fills to S beats and holds.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 16'(acc); b = 16'(acc); cin = 1'b0; sub = 1'b0;
      #1;
      if (in_ready) acc++;
      tick();
    end
    #1;
    chk("bp_accepted", 64'(acc), 64'(S));
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_sum_hold", {48'd0, sum}, 64'd0);
    tick();
    chk("bp_sum_hold2", {48'd0, sum}, 64'd0);
    out_ready = 1'b1; got = 0; n = 0;
    while (got < 10 && n < 60) begin
      in_valid = (acc < 10); a = 16'(acc); b = 16'(acc);
      #1;
      if (out_valid) begin
        chk("bp_order", {48'd0, sum}, 64'(2 * got));
        got++;
      end
      if (in_valid && in_ready) acc++;
      tick(); n++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd10);
    tick();
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Random handshake against the model.
    beats = 0; n = 0; hold = 1'b0; hs = 16'h0; hc = 1'b0; ho = 1'b0;
    while (beats < 1000 && n < 6000) begin
      in_valid = 1'($urandom_range(0, 1)); a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        chk("rnd_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("rnd_hold_sum", {48'd0, sum}, {48'd0, hs});
        chk("rnd_hold_flags", {62'd0, cout, overflow}, {62'd0, hc, ho});
      end
      if (in_valid && in_ready) begin
        mq.push_back(ref_model(W, {16'd0, a}, {16'd0, b}, cin, sub));
        beats++;
      end
      if (out_valid && out_ready) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_extra: got unexpected beat %0h expected none", sum);
        end else begin
          e = mq.pop_front();
          chk("rnd_sum", {48'd0, sum}, {32'd0, e.sum});
          chk("rnd_flags", {62'd0, cout, overflow}, {62'd0, e.cout, e.ovf});
        end
      end
      hold = out_valid && !out_ready; hs = sum; hc = cout; ho = overflow;
      tick(); n++;
    end
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (mq.size() > 0 && n < 50) begin
      #1;
      if (out_valid) begin
        e = mq.pop_front();
        chk("rnd_drain_sum", {48'd0, sum}, {32'd0, e.sum});
        chk("rnd_drain_flags", {62'd0, cout, overflow}, {62'd0, e.cout, e.ovf});
      end
      tick(); n++;
    end
    chk("rnd_beats", 64'(beats), 64'd1000);
    chk("rnd_queue_empty", 64'(mq.size()), 64'd0);

    // Mid-flight reset with three beats inside and one at the output.
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
    a = 16'h1111; b = 16'h1111; tick();
    a = 16'h2222; b = 16'h2222; tick();
    a = 16'h3333; b = 16'h3333; tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("mid_pre_sum", {48'd0, sum}, 64'h2222);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_sum", {48'd0, sum}, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1; acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) acc++;
    end
    chk("mid_no_stale", 64'(acc), 64'd0);
    send_one(16'h1234, 16'h1111, 1'b0, 1'b0, lat, rs, rc, ro);
    chk("mid_after_lat", 64'(lat), 64'(S));
    chk("mid_after_sum", {48'd0, rs}, 64'h2345);
    tick();

    // Parameter sweep on the extra instances, then drain.
    sw_valid = 1'b1; sw_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
      #1;
      sw_mon(0, 8, 1, rdy1, v1, {24'd0, s1}, c1, o1);
      sw_mon(1, 8, 8, rdy2, v2, {24'd0, s2}, c2, o2);
      sw_mon(2, 32, 4, rdy3, v3, s3, c3, o3);
      tick();
    end
    sw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      sw_mon(0, 8, 1, rdy1, v1, {24'd0, s1}, c1, o1);
      sw_mon(1, 8, 8, rdy2, v2, {24'd0, s2}, c2, o2);
      sw_mon(2, 32, 4, rdy3, v3, s3, c3, o3);
      tick();
    end
    for (int i = 0; i < 3; i++) chk($sformatf("sweep%0d_empty", i), 64'(swq[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
